// File: rtl/sub_div_ctrl.sv
// -----------------------------------------------------------------------------
// sub_div_ctrl
//
// Unsigned divider sequencer built around an external subtractor SFR
// (Q <= D on ld, Q <= Q - S on sub). The dividend is loaded into the SFR and
// the divisor is subtracted once per cycle while the SFR value is still
// >= divisor. The number of subtracts is the quotient and the residue left in
// the SFR is the remainder.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a division (sampled only while idle)
//   abort      cancel a division in LOAD/CHECK, no done is produced
//   dividend   unsigned dividend, sampled with start
//   divisor    unsigned divisor, sampled with start
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse when quotient/remainder/div_zero are valid
//   div_zero   divisor was zero (held until the next accepted start)
//   quotient   result (held until the next accepted start)
//   remainder  result (held until the next accepted start)
//   sfr_ld     SFR load strobe
//   sfr_sub    SFR subtract strobe
//   sfr_D      SFR load data, the latched dividend
//   sfr_S      SFR subtrahend, the latched divisor
//   sfr_Q      SFR current value
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; results of the last operation are held
// LOAD  | SFR is loaded with the latched dividend
// CHECK | one subtract per cycle while sfr_Q >= divisor, then capture results
// DONE  | results valid, done pulses for this single cycle
// -----------------------------------------------------------------------------
module sub_div_ctrl #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            sfr_ld,
    output logic            sfr_sub,
    output logic [SIZE-1:0] sfr_D,
    output logic [SIZE-1:0] sfr_S,
    input  logic [SIZE-1:0] sfr_Q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t          state;
    logic [SIZE-1:0] count;
    logic            q_ge_s;

    // The compare runs against the latched divisor, so the subtract strobe
    // and the SFR subtrahend always agree.
    assign q_ge_s  = (sfr_Q >= sfr_S);

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign sfr_ld  = (state == LOAD);
    assign sfr_sub = (state == CHECK) && q_ge_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            sfr_D     <= '0;
            sfr_S     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sfr_D <= dividend;
                        sfr_S <= divisor;
                        count <= '0;
                        if (divisor == '0) begin
                            // Divide by zero is reported without touching the SFR.
                            div_zero  <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= DONE;
                        end else begin
                            div_zero  <= 1'b0;
                            quotient  <= '0;
                            remainder <= '0;
                            state     <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    state <= abort ? IDLE : CHECK;
                end

                CHECK: begin
                    if (abort) begin
                        // Results stay at their cleared values.
                        state <= IDLE;
                    end else if (q_ge_s) begin
                        count <= count + ONE;
                    end else begin
                        quotient  <= count;
                        remainder <= sfr_Q;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The SFR must never see load and subtract together, and done is a pulse.
    assert property (@(posedge clk) disable iff (!rst_n) !(sfr_ld && sfr_sub));
    assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule
